// File: rtl/csa_accumulator_if.sv
// rtl/csa_accumulator_if.sv - row input and result output bundle for csa_accumulator
interface csa_accumulator_if;
    logic         row_valid;
    logic         row_ready;
    logic [127:0] row_data;
    logic         row_last;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic [7:0]   row_count;

    modport master (
        output row_valid, row_data, row_last, res_ready,
        input  row_ready, res_valid, res_data, row_count
    );

    modport slave (
        input  row_valid, row_data, row_last, res_ready,
        output row_ready, res_valid, res_data, row_count
    );
endinterface

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save row accumulator with final carry-propagate resolve
// Optional CSA_ACC_CHUNKED_CPA_EN: resolve one CHUNK_W slice per cycle with a registered carry.
module csa_accumulator #(
    parameter int CHUNK_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    csa_accumulator_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Elaboration fails on an unresolved module if the chunk width does not tile 128 bits.
    generate
        if (CHUNK_W <= 0 || (128 % CHUNK_W) != 0) begin : g_bad_chunk_w
            csa_accumulator_chunk_w_must_divide_128 u_bad ();
        end
    endgenerate

    logic [1:0]   state;
    logic [127:0] s_q;
    logic [127:0] c_q;
    logic [127:0] res_q;
    logic [7:0]   count_q;
    logic         accept;
    logic [126:0] maj;

    assign bus.row_ready = (state == IDLE) || (state == ACCUM);
    assign accept        = bus.row_valid && bus.row_ready;
    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = (state == DONE) ? res_q : '0;
    assign bus.row_count = count_q;

    // Majority bit 127 would shift out of the 128-bit carry word, so only 127 bits are formed.
    assign maj = (s_q[126:0] & c_q[126:0])
               | (s_q[126:0] & bus.row_data[126:0])
               | (c_q[126:0] & bus.row_data[126:0]);

`ifdef CSA_ACC_CHUNKED_CPA_EN
    localparam int NCHUNK = 128 / CHUNK_W;
    localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic [CIDX_W-1:0] chunk_idx;
    logic              chunk_carry;
    logic [CHUNK_W:0]  chunk_sum;
    logic              chunk_last;

    assign chunk_sum  = {1'b0, s_q[int'(chunk_idx)*CHUNK_W +: CHUNK_W]}
                      + {1'b0, c_q[int'(chunk_idx)*CHUNK_W +: CHUNK_W]}
                      + (CHUNK_W+1)'(chunk_carry);
    assign chunk_last = (int'(chunk_idx) == NCHUNK - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            count_q <= '0;
`ifdef CSA_ACC_CHUNKED_CPA_EN
            chunk_idx   <= '0;
            chunk_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        s_q   <= s_q ^ c_q ^ bus.row_data;
                        c_q   <= {maj, 1'b0};
                        if (count_q != 8'hFF)
                            count_q <= count_q + 8'd1;
                        state <= bus.row_last ? RESOLVE : ACCUM;
                    end
                end
                RESOLVE: begin
`ifdef CSA_ACC_CHUNKED_CPA_EN
                    res_q[int'(chunk_idx)*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    if (chunk_last) begin
                        chunk_idx   <= '0;
                        chunk_carry <= 1'b0;
                        state       <= DONE;
                    end else begin
                        chunk_idx   <= chunk_idx + 1'b1;
                        chunk_carry <= chunk_sum[CHUNK_W];
                    end
`else
                    res_q <= s_q + c_q;
                    state <= DONE;
`endif
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state   <= IDLE;
                        s_q     <= '0;
                        c_q     <= '0;
                        res_q   <= '0;
                        count_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
